// File: rtl/uart_tx_frame_ctrl_pkg.sv
// Shared UART constants: one-hot frame states, parity mode flags and data width.
package uart_tx_frame_ctrl_pkg;

    localparam int unsigned DATA_BITS = 8;

    localparam logic [4:0] ST_INTERVAL  = 5'b0_0001;
    localparam logic [4:0] ST_STARTBIT  = 5'b0_0010;
    localparam logic [4:0] ST_DATABITS  = 5'b0_0100;
    localparam logic [4:0] ST_PARITYBIT = 5'b0_1000;
    localparam logic [4:0] ST_STOPBIT   = 5'b1_0000;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;
    localparam logic EVEN    = 1'b0;
    localparam logic ODD     = 1'b1;

    typedef enum logic [4:0] {
        S_INTERVAL  = ST_INTERVAL,
        S_STARTBIT  = ST_STARTBIT,
        S_DATABITS  = ST_DATABITS,
        S_PARITYBIT = ST_PARITYBIT,
        S_STOPBIT   = ST_STOPBIT
    } frame_state_e;

endpackage

// File: rtl/uart_tx_frame_ctrl_if.sv
// Byte handshake channel into the UART TX frame controller.
interface uart_tx_frame_ctrl_if;
    import uart_tx_frame_ctrl_pkg::*;

    logic [DATA_BITS-1:0] Data;
    logic                 DataValid;
    logic                 ParityEnable;
    logic                 Ready;

    modport master (
        output Data,
        output DataValid,
        output ParityEnable,
        input  Ready
    );

    modport slave (
        input  Data,
        input  DataValid,
        input  ParityEnable,
        output Ready
    );

endinterface

// File: rtl/uart_tx_frame_ctrl.sv
// UART TX frame sequencer: INTERVAL -> START -> 8 DATA -> [PARITY] -> STOP on baud pulses,
// feeding the parity generator its state, held byte and calculation trigger.
module uart_tx_frame_ctrl
    import uart_tx_frame_ctrl_pkg::*;
#(
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 p_BaudSig_i,
    uart_tx_frame_ctrl_if.slave  tx_if,
    input  logic                 ParityResult_i,
    output logic                 Tx_o,
    output logic [4:0]           State_o,
    output logic [DATA_BITS-1:0] TxData_o,
    output logic                 p_ParityCalTrigger_o,
    output logic                 Busy_o
);

    localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    frame_state_e         state_q;
    logic                 tx_q;
    logic                 ready_q;
    logic                 busy_q;
    logic                 pend_q;
    logic                 par_en_q;
    logic                 trig_q;
    logic [3:0]           cnt_q;
    logic [DATA_BITS-1:0] data_q;

    logic                 accept;
    logic [2:0]           bit_idx_d;

    assign accept    = tx_if.DataValid & ready_q;
    assign bit_idx_d = cnt_q[2:0] + 3'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_INTERVAL;
            tx_q     <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            pend_q   <= 1'b0;
            par_en_q <= DISABLE;
            trig_q   <= 1'b0;
            cnt_q    <= '0;
            data_q   <= '0;
        end else begin
            trig_q <= 1'b0;

            // ready_q is low whenever pend_q is set, so capture never races the start below
            if (accept) begin
                data_q   <= tx_if.Data;
                par_en_q <= tx_if.ParityEnable;
                pend_q   <= 1'b1;
                ready_q  <= 1'b0;
                busy_q   <= 1'b1;
            end

            unique case (state_q)
                S_INTERVAL: begin
                    tx_q <= 1'b1;
                    if (pend_q && p_BaudSig_i) begin
                        state_q <= S_STARTBIT;
                        pend_q  <= 1'b0;
                        tx_q    <= 1'b0;
                    end
                end
                S_STARTBIT: begin
                    if (p_BaudSig_i) begin
                        state_q <= S_DATABITS;
                        cnt_q   <= '0;
                        tx_q    <= data_q[0];
                    end
                end
                S_DATABITS: begin
                    if (p_BaudSig_i) begin
                        trig_q <= (cnt_q == 4'd0);
                        if (cnt_q == LAST_BIT) begin
                            cnt_q <= '0;
                            if (par_en_q == ENABLE) begin
                                state_q <= S_PARITYBIT;
                                tx_q    <= ParityResult_i;
                            end else begin
                                state_q <= S_STOPBIT;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                            tx_q  <= data_q[bit_idx_d];
                        end
                    end
                end
                S_PARITYBIT: begin
                    if (p_BaudSig_i) begin
                        state_q <= S_STOPBIT;
                        cnt_q   <= '0;
                        tx_q    <= 1'b1;
                    end
                end
                S_STOPBIT: begin
                    tx_q <= 1'b1;
                    if (p_BaudSig_i) begin
                        if (cnt_q == LAST_STOP) begin
                            state_q <= S_INTERVAL;
                            cnt_q   <= '0;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_q <= S_INTERVAL;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign tx_if.Ready          = ready_q;
    assign Tx_o                 = tx_q;
    assign State_o              = state_q;
    assign TxData_o             = data_q;
    assign p_ParityCalTrigger_o = trig_q;
    assign Busy_o               = busy_q;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Randomised scoreboard bench: a line-sampling receiver compares every bit period against expected frames.
module tb_uart_tx_frame_ctrl;
    import uart_tx_frame_ctrl_pkg::*;

    localparam int unsigned TB_STOP = 2;
    localparam int unsigned DIV     = 6;
    localparam int unsigned MID     = 3;

    logic       clk;
    logic       rst;
    logic       p_baud;
    logic       par_res;
    logic       tx;
    logic [4:0] st;
    logic [7:0] txd;
    logic       trig;
    logic       busy;

    uart_tx_frame_ctrl_if tx_bus();

    uart_tx_frame_ctrl #(.STOP_BITS(TB_STOP)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .p_BaudSig_i          (p_baud),
        .tx_if                (tx_bus),
        .ParityResult_i       (par_res),
        .Tx_o                 (tx),
        .State_o              (st),
        .TxData_o             (txd),
        .p_ParityCalTrigger_o (trig),
        .Busy_o               (busy)
    );

    typedef struct { logic [7:0] data; logic pe; logic odd; } item_t;
    typedef struct { logic bit_v; logic [4:0] st; } slot_t;

    item_t       exp_q[$];
    slot_t       frame_q[$];
    item_t       cur;
    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned pushed = 0;
    int unsigned done_frames = 0;
    int unsigned fpos = 0;
    int unsigned trig_cnt = 0;
    int unsigned gap = 0;
    int unsigned ago = 0;
    int unsigned bcnt = 0;
    bit          in_frame = 0;
    bit          after_frame = 0;
    bit          prev_valid = 0;
    logic        baud_prev = 0;
    logic        prev_tx;
    logic [4:0]  prev_st;
    logic        odd_mode = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Expected line image of one frame: start, LSB-first data, optional parity, stop bits.
    task automatic build_frame(input item_t it);
        frame_q.delete();
        frame_q.push_back('{1'b0, 5'b0_0010});
        for (int i = 0; i < 8; i++) frame_q.push_back('{it.data[i], 5'b0_0100});
        if (it.pe) frame_q.push_back('{(^it.data) ^ it.odd, 5'b0_1000});
        for (int i = 0; i < int'(TB_STOP); i++) frame_q.push_back('{1'b1, 5'b1_0000});
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        p_baud = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bcnt   = (bcnt == DIV - 1) ? 0 : bcnt + 1;
            p_baud = (bcnt == 0);
        end
    end

    // Parity generator model: evaluates the held byte on the trigger and holds its result.
    always @(negedge clk) begin
        if (trig) par_res = (^txd) ^ odd_mode;
    end

    always @(negedge clk) begin
        ago       = baud_prev ? 1 : ago + 1;
        baud_prev = p_baud;
        if (!rst) begin
            in_frame    = 0;
            after_frame = 0;
            prev_valid  = 0;
            fpos        = 0;
            frame_q.delete();
        end else begin
            if (prev_valid && ago != 1) begin
                chk("hold_tx", tx, prev_tx);
                chk("hold_state", st, prev_st);
            end
            if (prev_valid && ago == 1 && prev_st == 5'b1_0000 && st == 5'b0_0001) begin
                chk("ready_on_interval", tx_bus.Ready, 1);
                chk("busy_on_interval", busy, 0);
            end
            if (trig) begin
                trig_cnt++;
                chk("trig_position", {in_frame, fpos == 2, ago == 1}, 3'b111);
            end
            if (ago == MID) begin
                if (!in_frame) begin
                    if (tx == 1'b0) begin
                        chk("frame_expected", exp_q.size() != 0, 1);
                        if (after_frame) chk("idle_gap", gap >= 1, 1);
                        if (exp_q.size() != 0) begin
                            cur = exp_q.pop_front();
                            build_frame(cur);
                            in_frame = 1;
                            fpos     = 0;
                            trig_cnt = 0;
                        end
                    end else begin
                        chk("idle_state", st, 5'b0_0001);
                        gap++;
                    end
                end
                if (in_frame) begin
                    slot_t s;
                    s = frame_q.pop_front();
                    chk("tx_bit", tx, s.bit_v);
                    chk("state", st, s.st);
                    chk("txdata_held", txd, cur.data);
                    chk("busy_in_frame", busy, 1);
                    chk("ready_in_frame", tx_bus.Ready, 0);
                    fpos++;
                    if (frame_q.size() == 0) begin
                        chk("trig_count", trig_cnt, 1);
                        in_frame    = 0;
                        after_frame = 1;
                        gap         = 0;
                        done_frames++;
                    end
                end
            end
            prev_tx    = tx;
            prev_st    = st;
            prev_valid = 1;
        end
    end

    task automatic wait_ready();
        int unsigned t = 0;
        while (!tx_bus.Ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (!tx_bus.Ready) chk("ready_timeout", tx_bus.Ready, 1);
    endtask

    task automatic send(input logic [7:0] b, input logic pe, input logic odd);
        @(negedge clk);
        wait_ready();
        tx_bus.Data         = b;
        tx_bus.ParityEnable = pe;
        tx_bus.DataValid    = 1'b1;
        odd_mode            = odd;
        exp_q.push_back('{b, pe, odd});
        pushed++;
        @(negedge clk);
        tx_bus.DataValid = 1'b0;
        chk("ready_low_after_xfer", tx_bus.Ready, 0);
        chk("busy_high_after_xfer", busy, 1);
    endtask

    initial begin
        int unsigned t;
        rst                 = 1'b0;
        par_res             = 1'b0;
        tx_bus.Data         = '0;
        tx_bus.DataValid    = 1'b0;
        tx_bus.ParityEnable = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_state", st, 5'b0_0001);
        chk("rst_ready", tx_bus.Ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_txdata", txd, 8'h00);
        chk("rst_trig", trig, 0);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);

        send(8'hA5, 1'b1, EVEN);
        send(8'h01, 1'b1, ODD);
        send(8'h03, 1'b1, ODD);
        send(8'h3C, 1'b0, EVEN);

        // transfer coinciding with a baud pulse must wait for the following pulse
        t = 0;
        @(negedge clk);
        while (!(tx_bus.Ready && p_baud) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("sync_wait", tx_bus.Ready && p_baud, 1);
        tx_bus.Data         = 8'h96;
        tx_bus.ParityEnable = 1'b1;
        tx_bus.DataValid    = 1'b1;
        odd_mode            = EVEN;
        exp_q.push_back('{8'h96, 1'b1, EVEN});
        pushed++;
        @(negedge clk);
        tx_bus.DataValid = 1'b0;
        chk("same_pulse_no_start", st, 5'b0_0001);
        chk("same_pulse_busy", busy, 1);
        repeat (DIV) @(negedge clk);
        chk("next_pulse_start", st, 5'b0_0010);

        send(8'h81, 1'b1, EVEN);
        tx_bus.Data         = 8'hFF;
        tx_bus.ParityEnable = 1'b1;
        tx_bus.DataValid    = 1'b1;
        repeat (40) @(negedge clk);
        tx_bus.DataValid = 1'b0;

        send(8'hC3, 1'b1, ODD);
        t = 0;
        while (!(in_frame && fpos >= 6) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("reached_bit4", fpos, 6);
        #2 rst = 1'b0;
        #1;
        chk("midrst_tx", tx, 1);
        chk("midrst_state", st, 5'b0_0001);
        chk("midrst_ready", tx_bus.Ready, 1);
        chk("midrst_busy", busy, 0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;

        send(8'h55, 1'b1, EVEN);
        send(8'h12, 1'b0, EVEN);
        send(8'h34, 1'b1, ODD);

        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        t = 0;
        while ((exp_q.size() != 0 || in_frame) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        repeat (3 * DIV) @(negedge clk);
        chk("frames_done", done_frames, pushed - 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
